// File: rtl/pam4_rx_pkg.sv
// Shared constants and types for the PAM4 RGB receive path.
// Channel count, run-counter width, level encoding and the per-channel run state.
package pam4_rx_pkg;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 12;
  localparam int CH_W   = 2;

  localparam logic LEVEL_HIGH = 1'b1;
  localparam logic LEVEL_LOW  = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Round-robin successor of a channel index, wrapping after the last channel.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (int'(ch) == NUM_CH - 1) ? '0 : ch + CH_W'(1);
  endfunction

endpackage

// File: rtl/edge_run_meter_if.sv
// Run-record stream from edge_run_meter to the symbol decoder (valid/ready).
// master = record producer, slave = consumer.
interface edge_run_meter_if #(
  parameter int CNT_W = pam4_rx_pkg::CNT_W
);
  import pam4_rx_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic             out_level;
  logic [CNT_W-1:0] out_width;
  logic             out_sat;

  modport master (
    output out_valid, out_ch, out_level, out_width, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ch, out_level, out_width, out_sat,
    output out_ready
  );

endinterface

// File: rtl/edge_run_counter.sv
// One channel: IDLE/RUN state, saturating run-length counter and a 1-deep
// pending record register that the top-level arbiter drains via grant.
module edge_run_counter
  import pam4_rx_pkg::*;
#(
  parameter int CNT_W = pam4_rx_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise,
  input  logic             fall,
  input  logic             grant,
  output logic             pend_valid,
  output logic             pend_level,
  output logic [CNT_W-1:0] pend_width,
  output logic             pend_sat,
  output logic             drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  run_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             any_edge;
  logic             close_level;
  logic             offer;

  assign any_edge    = rise | fall;
  // A simultaneous rise+fall is treated as a rise: the run that ends was low.
  assign close_level = rise ? LEVEL_LOW : LEVEL_HIGH;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    offer     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_edge) begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_RUN: begin
        if (any_edge) begin
          offer   = 1'b1;
          cnt_nxt = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A grant empties the slot this cycle, so a coincident offer is never a drop.
  assign drop = offer && pend_valid && !grant;

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the pending record fields are reset too, so a reset leaves all outputs at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_level <= 1'b0;
      pend_width <= '0;
      pend_sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (offer && !drop) begin
        pend_valid <= 1'b1;
        pend_level <= close_level;
        pend_width <= cnt;
        pend_sat   <= (cnt == CNT_MAX);
      end else if (grant) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/edge_run_meter.sv
// Measures runs between edges on NUM_CH channels and merges the completed runs
// into one valid/ready record stream through a round-robin arbiter.
module edge_run_meter
  import pam4_rx_pkg::*;
#(
  parameter int CNT_W = pam4_rx_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] rising_edge,
  input  logic [NUM_CH-1:0] falling_edge,
  input  logic              clr_ovf,
  output logic [NUM_CH-1:0] ovf,
  edge_run_meter_if.master  rec
);

  logic [NUM_CH-1:0] pend_valid;
  logic [NUM_CH-1:0] pend_level;
  logic [NUM_CH-1:0] pend_sat;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] grant;
  logic [CNT_W-1:0]  pend_width [NUM_CH];

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gnt_ch;
  logic              any_pend;
  logic              load_en;
  int                idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_run_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .rise       (rising_edge[g]),
      .fall       (falling_edge[g]),
      .grant      (grant[g]),
      .pend_valid (pend_valid[g]),
      .pend_level (pend_level[g]),
      .pend_width (pend_width[g]),
      .pend_sat   (pend_sat[g]),
      .drop       (drop[g])
    );
  end

  // The output register may take a new record when empty or when it is leaving.
  assign load_en = !rec.out_valid || rec.out_ready;

  always_comb begin
    any_pend = 1'b0;
    gnt_ch   = '0;
    grant    = '0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!any_pend && pend_valid[idx]) begin
        any_pend = 1'b1;
        gnt_ch   = CH_W'(idx);
      end
    end
    if (load_en && any_pend) grant[gnt_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec.out_valid <= 1'b0;
      rec.out_ch    <= '0;
      rec.out_level <= 1'b0;
      rec.out_width <= '0;
      rec.out_sat   <= 1'b0;
      ptr           <= '0;
      ovf           <= '0;
    end else begin
      if (load_en) begin
        rec.out_valid <= any_pend;
        if (any_pend) begin
          rec.out_ch    <= gnt_ch;
          rec.out_level <= pend_level[gnt_ch];
          rec.out_width <= pend_width[gnt_ch];
          rec.out_sat   <= pend_sat[gnt_ch];
          ptr           <= next_ch(gnt_ch);
        end
      end
      // A drop in the same cycle as the clear still leaves its flag set.
      ovf <= (clr_ovf ? '0 : ovf) | drop;
    end
  end

endmodule

// File: tb/tb_edge_run_meter.sv
// Self-checking bench for edge_run_meter: directed table, hand-written corner
// sequences and random stimulus against a timestamp-based reference model.
module tb_edge_run_meter;
  import pam4_rx_pkg::*;

  localparam int MAX_M = 4095;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rise, fall;
  logic       clr;
  logic [2:0] ovf;
  logic [2:0] s_rise, s_fall;
  logic       s_clr;
  logic [2:0] s_ovf;

  edge_run_meter_if #(.CNT_W(12)) m_if ();
  edge_run_meter_if #(.CNT_W(4))  s_if ();

  edge_run_meter #(.CNT_W(12)) dut (
    .clk(clk), .rst(rst), .rising_edge(rise), .falling_edge(fall),
    .clr_ovf(clr), .ovf(ovf), .rec(m_if)
  );

  edge_run_meter #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .rising_edge(s_rise), .falling_edge(s_fall),
    .clr_ovf(s_clr), .ovf(s_ovf), .rec(s_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel remembers the cycle of its last edge; a run's
  // width is the cycle difference, clipped to MAX_M. Pending slots and the output
  // record are plain variables; the arbiter is a search from the pointer.
  typedef struct {
    logic [1:0] ch;
    logic       level;
    int         width;
    logic       sat;
  } rec_t;

  bit         m_run  [3];
  int         m_last [3];
  bit         m_pv   [3];
  rec_t       m_pend [3];
  bit         m_ov;
  rec_t       m_out;
  int         m_ptr;
  logic [2:0] m_ovf;

  task automatic model_step();
    logic [2:0] drops;
    int         g;
    int         gap;
    bit         r, f;
    rec_t       nr;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_run[i] = 0;
        m_pv[i]  = 0;
      end
      m_ov  = 0;
      m_ptr = 0;
      m_ovf = '0;
      return;
    end
    if (!m_ov || m_if.out_ready) begin
      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && m_pv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      if (g >= 0) begin
        m_out   = m_pend[g];
        m_pv[g] = 0;
        m_ptr   = (g + 1) % 3;
        m_ov    = 1;
      end else begin
        m_ov = 0;
      end
    end
    drops = '0;
    for (int c = 0; c < 3; c++) begin
      r = rise[c];
      f = fall[c] && !rise[c];
      if (r || f) begin
        if (m_run[c]) begin
          gap      = cyc - m_last[c];
          nr.ch    = 2'(c);
          nr.level = f;
          nr.width = (gap > MAX_M) ? MAX_M : gap;
          nr.sat   = (gap >= MAX_M);
          if (m_pv[c]) drops[c] = 1'b1;
          else begin
            m_pend[c] = nr;
            m_pv[c]   = 1;
          end
        end
        m_run[c]  = 1;
        m_last[c] = cyc;
      end
    end
    m_ovf = (clr ? 3'b000 : m_ovf) | drops;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("mdl_valid", 32'(m_if.out_valid), 32'(m_ov));
    if (m_ov) begin
      check("mdl_ch",    32'(m_if.out_ch),    32'(m_out.ch));
      check("mdl_level", 32'(m_if.out_level), 32'(m_out.level));
      check("mdl_width", 32'(m_if.out_width), m_out.width);
      check("mdl_sat",   32'(m_if.out_sat),   32'(m_out.sat));
    end
    check("mdl_ovf", 32'(ovf), 32'(m_ovf));
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       ready;
    logic       ev;
    int         ech;
    logic       elvl;
    int         ew;
  } vec_t;

  vec_t vec [22];

  function automatic vec_t mk(input logic r, input logic [2:0] ri, input logic [2:0] fa,
                              input logic rdy, input logic ev, input int ech,
                              input logic el, input int ew);
    vec_t v;
    v.rst = r; v.rise = ri; v.fall = fa; v.ready = rdy;
    v.ev = ev; v.ech = ech; v.elvl = el; v.ew = ew;
    return v;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Single pulse on ch1 (edges at rows 0, 5, 8), then reset and a
    // back-pressured three-channel collision resolved in round-robin order.
    vec[0]  = mk(0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
    vec[1]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
    vec[2]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
    vec[3]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
    vec[4]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
    vec[5]  = mk(0, 3'b000, 3'b010, 1, 0, 0, 0, 0);
    vec[6]  = mk(0, 3'b000, 3'b000, 1, 1, 1, 1, 5);
    vec[7]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
    vec[8]  = mk(0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
    vec[9]  = mk(0, 3'b000, 3'b000, 1, 1, 1, 0, 3);
    vec[10] = mk(0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
    vec[11] = mk(1, 3'b000, 3'b000, 1, 0, 0, 0, 0);
    vec[12] = mk(0, 3'b001, 3'b000, 0, 0, 0, 0, 0);
    vec[13] = mk(0, 3'b010, 3'b000, 0, 0, 0, 0, 0);
    vec[14] = mk(0, 3'b100, 3'b000, 0, 0, 0, 0, 0);
    vec[15] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    vec[16] = mk(0, 3'b000, 3'b111, 0, 0, 0, 0, 0);
    vec[17] = mk(0, 3'b000, 3'b000, 0, 1, 0, 1, 4);
    vec[18] = mk(0, 3'b000, 3'b000, 0, 1, 0, 1, 4);
    vec[19] = mk(0, 3'b000, 3'b000, 1, 1, 1, 1, 3);
    vec[20] = mk(0, 3'b000, 3'b000, 1, 1, 2, 1, 2);
    vec[21] = mk(0, 3'b000, 3'b000, 1, 0, 0, 0, 0);

    rst = 1'b1; rise = '0; fall = '0; clr = 1'b0; m_if.out_ready = 1'b1;
    s_rise = '0; s_fall = '0; s_clr = 1'b0; s_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_last[i] = 0; m_pv[i] = 0;
    end
    m_ov = 0; m_ptr = 0; m_ovf = '0;

    // Reset, then the first edge only starts a run.
    tick(); tick();
    rst = 1'b0;
    check("rst_valid",   32'(m_if.out_valid), 0);
    check("rst_ovf",     32'(ovf), 0);
    check("rst_s_valid", 32'(s_if.out_valid), 0);
    rise = 3'b001; tick(); rise = '0; tick(); tick();
    check("first_edge_no_rec", 32'(m_if.out_valid), 0);

    for (int i = 0; i < 22; i++) begin
      rst = vec[i].rst; rise = vec[i].rise; fall = vec[i].fall;
      m_if.out_ready = vec[i].ready;
      tick();
      check("vec_valid", 32'(m_if.out_valid), 32'(vec[i].ev));
      check("vec_ovf",   32'(ovf), 0);
      if (vec[i].ev) begin
        check("vec_ch",    32'(m_if.out_ch),    vec[i].ech);
        check("vec_level", 32'(m_if.out_level), 32'(vec[i].elvl));
        check("vec_width", 32'(m_if.out_width), vec[i].ew);
      end
    end
    rst = 1'b0; rise = '0; fall = '0;

    // Overflow: ch2 closes three runs while the consumer stalls.
    m_if.out_ready = 1'b0;
    rise = 3'b100; tick(); rise = '0;
    fall = 3'b100; tick(); fall = '0;
    rise = 3'b100; tick(); rise = '0;
    check("ovf_set",       32'(ovf), 32'(3'b100));
    check("ovf_out_valid", 32'(m_if.out_valid), 1);
    check("ovf_out_ch",    32'(m_if.out_ch), 2);
    check("ovf_out_level", 32'(m_if.out_level), 0);
    check("ovf_out_width", 32'(m_if.out_width), 6);
    tick();
    check("ovf_sticky", 32'(ovf), 32'(3'b100));
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
    m_if.out_ready = 1'b1;
    tick();
    check("ovf_second_level", 32'(m_if.out_level), 1);
    check("ovf_second_width", 32'(m_if.out_width), 1);
    tick();
    check("ovf_drained", 32'(m_if.out_valid), 0);

    // Reset while a record is shown and another is pending.
    m_if.out_ready = 1'b0;
    fall = 3'b011; tick(); fall = '0; tick();
    check("mid_rst_pre_valid", 32'(m_if.out_valid), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_valid", 32'(m_if.out_valid), 0);
    check("mid_rst_ovf",   32'(ovf), 0);
    m_if.out_ready = 1'b1;
    rise = 3'b001; tick(); rise = '0; tick(); tick();
    check("mid_rst_first_edge", 32'(m_if.out_valid), 0);

    // Saturation on the 4-bit instance: gaps of 20, 3, 15 and 14 cycles.
    s_rise = 3'b001; tick(); s_rise = '0;
    repeat (19) tick();
    s_fall = 3'b001; tick(); s_fall = '0;
    tick();
    check("sat20_valid", 32'(s_if.out_valid), 1);
    check("sat20_width", 32'(s_if.out_width), 15);
    check("sat20_sat",   32'(s_if.out_sat), 1);
    check("sat20_level", 32'(s_if.out_level), 1);
    tick();
    s_rise = 3'b001; tick(); s_rise = '0;
    tick();
    check("gap3_width", 32'(s_if.out_width), 3);
    check("gap3_sat",   32'(s_if.out_sat), 0);
    check("gap3_level", 32'(s_if.out_level), 0);
    repeat (13) tick();
    s_fall = 3'b001; tick(); s_fall = '0;
    tick();
    check("gap15_width", 32'(s_if.out_width), 15);
    check("gap15_sat",   32'(s_if.out_sat), 1);
    repeat (12) tick();
    s_rise = 3'b001; tick(); s_rise = '0;
    tick();
    check("gap14_width", 32'(s_if.out_width), 14);
    check("gap14_sat",   32'(s_if.out_sat), 0);

    // Random traffic against the model, including illegal rise+fall and stalls.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < 3; c++) begin
        rise[c] = ($urandom_range(0, 5) == 0);
        fall[c] = ($urandom_range(0, 5) == 0);
      end
      clr            = ($urandom_range(0, 39) == 0);
      m_if.out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0; rise = '0; fall = '0; clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
